clk_period_meter: RTL and testbench
===================================

# clk_period_meter

Measures an incoming slow clock or toggling signal in `i_clk` cycles. It reports the full period, the high time and the equivalent divider half-period count, so the control logic can check or close the loop on any divided clock the design generates. It sits beside the variable clock divider on the Basys3 USB design: the divider turns a count into a clock, and this block recovers the count from a clock. Fully synchronous to `i_clk`. The measured input is asynchronous and is synchronized internally.

## Interface

- `COUNT_WIDTH`, default 32: width of all count outputs and of the internal counter.
- `SYNC_STAGES`, default 2: synchronizer flop count on `i_sig`. Minimum 2.
- `TIMEOUT`, default 100_000_000: cycles without a rising edge before loss of lock. Must be less than 2^COUNT_WIDTH.

Ports:

- `i_clk`, input, 1: system clock.
- `i_rst`, input, 1: reset, synchronous, active-high.
- `i_sig`, input, 1: asynchronous signal being measured.
- `i_en`, input, 1: measurement enable.
- `o_period`, output, COUNT_WIDTH: `i_clk` cycles between the last two rising edges.
- `o_high`, output, COUNT_WIDTH: `i_clk` cycles from the last rising edge to the following falling edge.
- `o_div_count`, output, COUNT_WIDTH: (o_period >> 1) − 1, floored at 0. This is the value a divider needs to reproduce the period.
- `o_valid`, output, 1: one-cycle pulse when the three result outputs update.
- `o_locked`, output, 1: at least one full period has been measured since arming, with no timeout since.
- `o_timeout`, output, 1: no rising edge within TIMEOUT cycles. Sticky until the next rising edge.

## Operation

**Front end**
- `i_sig` passes through SYNC_STAGES flops to give `s`.
- `s_d` is `s` delayed by one flop.
- `rise` = s & ~s_d; `fall` = ~s & s_d. Both are combinational and never coincide.
- The synchronizer runs in every state, including IDLE.

**States**
- **IDLE**
  - Entered on reset or whenever `i_en` = 0.
  - `cnt` = 0, `o_locked` = 0, `o_timeout` = 0.
  - Result outputs hold their last values.
  - Goes to ARM on the cycle where `i_en` = 1.
- **ARM** (waiting for the first rising edge)
  - `cnt` increments and saturates at TIMEOUT−1.
  - When `cnt` = TIMEOUT−1: `o_timeout` <= 1.
  - On `rise`: `cnt` <= 0, `o_timeout` <= 0, go to MEASURE. No result is reported.
- **MEASURE**
  - `cnt` increments every cycle.
  - On `fall`: `hi` <= cnt+1.
  - On `rise`:
    - `o_period` <= cnt+1.
    - `o_high` <= `hi`.
    - `o_div_count` <= max(((cnt+1)>>1) − 1, 0).
    - `o_valid` <= 1, `o_locked` <= 1, `cnt` <= 0.
  - When `cnt` = TIMEOUT−1 and no `rise`: `o_timeout` <= 1, `o_locked` <= 0, `cnt` <= 0, go to ARM. The partial measurement is discarded.

**Priority and boundary rules**
- Priority: `i_rst` > `i_en` = 0 > `rise` > timeout > count.
- A `rise` in the same cycle as reaching TIMEOUT−1 counts as a valid edge.
- `hi` is not cleared between periods. A signal stuck high for one period (no `fall`) reports the previous `o_high`.
- All arithmetic is unsigned at COUNT_WIDTH. `cnt` cannot wrap because TIMEOUT < 2^COUNT_WIDTH.
- Reset mid-measurement: the next cycle is IDLE with all outputs zero. No `o_valid` is produced for the interrupted period.

## Timing

- Reset values: `o_period`, `o_high`, `o_div_count` = 0; `o_valid`, `o_locked`, `o_timeout` = 0.
- All outputs are registered.
- Edge latency: `o_valid` is high after the (SYNC_STAGES+1)-th `i_clk` edge, counting the edge that first samples `i_sig` high as edge 1. With SYNC_STAGES = 2 that is the third edge.
- `o_valid` is exactly one cycle wide. The result outputs are stable until the next `o_valid`.
- First result appears on the second rising edge after ARM is entered.
- Minimum measurable period: 2 cycles (`o_div_count` = 0). Minimum high/low time: 1 cycle.
- Input frequency must be at most `i_clk`/2 after synchronization. Shorter pulses may be missed.

## Test plan

1. **Divider-shaped input.** Drive `i_sig` high 5, low 5, repeated. Required:
   - No `o_valid` on the first rise.
   - On every later rise: `o_period` = 10, `o_high` = 5, `o_div_count` = 4, `o_locked` = 1.
   - `o_valid` 3 edges after the sampling edge (SYNC_STAGES = 2).
2. **Duty cycle and minimum period.** Drive high 3, low 7: `o_period` = 10, `o_high` = 3. Then drive high 1, low 1: `o_period` = 2, `o_high` = 1, `o_div_count` = 0.
3. **Timeout.** Set TIMEOUT = 50, lock on period 10, then hold `i_sig` low. Required:
   - `o_timeout` = 1 and `o_locked` = 0 exactly 50 cycles after the last detected rise.
   - Next rise: `o_timeout` = 0, no `o_valid`.
   - Following rise: `o_valid` with the correct period.
4. **Edge at timeout boundary.** With TIMEOUT = 50, present a period of exactly 50. Required: `o_valid` with `o_period` = 50, `o_timeout` stays 0.
5. **Enable and reset mid-period.** Drop `i_en` mid-period: next cycle `o_locked` = 0, result outputs hold, no `o_valid`. Assert `i_rst` mid-period: next cycle every output is 0. After re-enable, the first `o_valid` comes only on the second rise.

Source files
------------

// File: rtl/clk_period_meter.sv
// clk_period_meter
// Measures an asynchronous slow clock/toggle in i_clk cycles: full period,
// high time and the half-period count a clock divider needs to reproduce it.
// A saturating cycle counter runs between synchronized rising edges; a
// watchdog drops lock when no rising edge arrives within TIMEOUT cycles.
module clk_period_meter #(
  parameter int COUNT_WIDTH = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 100_000_000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_sig,
  input  logic                   i_en,
  output logic [COUNT_WIDTH-1:0] o_period,
  output logic [COUNT_WIDTH-1:0] o_high,
  output logic [COUNT_WIDTH-1:0] o_div_count,
  output logic                   o_valid,
  output logic                   o_locked,
  output logic                   o_timeout
);

  // Last counter value before the watchdog fires.
  localparam logic [COUNT_WIDTH-1:0] TO_LAST = COUNT_WIDTH'(TIMEOUT - 1);
  localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  // Counter increment that parks at the watchdog limit instead of running on.
  function automatic logic [COUNT_WIDTH-1:0] f_sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return (c == TO_LAST) ? c : c + ONE;
  endfunction

  // Divider half-period count for a period p: (p >> 1) - 1, floored at zero.
  function automatic logic [COUNT_WIDTH-1:0] f_div_count(input logic [COUNT_WIDTH-1:0] p);
    logic [COUNT_WIDTH-1:0] half;
    half = p >> 1;
    return (half == '0) ? '0 : half - ONE;
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;

  state_t                 r_state;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [COUNT_WIDTH-1:0] r_hi;
  logic [COUNT_WIDTH-1:0] r_period;
  logic [COUNT_WIDTH-1:0] r_high;
  logic [COUNT_WIDTH-1:0] r_div;
  logic                   r_valid;
  logic                   r_locked;
  logic                   r_timeout;
  logic [COUNT_WIDTH-1:0] w_cnt_inc;

  // Synchronizer chain plus one delay flop for edge detection; runs in every state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_s_d  <= r_sync[SYNC_STAGES-1];
    end
  end

  // ---- stage boundary: synchronized level -> edge strobes ----
  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_s & ~r_s_d;
  assign w_fall    = ~w_s & r_s_d;
  assign w_cnt_inc = r_cnt + ONE;

  // Measurement FSM: counts cycles between rising edges and registers results.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_div     <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!i_en) begin
        // Disabled: results hold, status and counter clear.
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_locked  <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_ARM;
          end
          S_ARM: begin
            // First rising edge only starts the count; nothing to report yet.
            if (w_rise) begin
              r_cnt     <= '0;
              r_timeout <= 1'b0;
              r_state   <= S_MEASURE;
            end else begin
              if (r_cnt == TO_LAST) r_timeout <= 1'b1;
              r_cnt <= f_sat_inc(r_cnt);
            end
          end
          S_MEASURE: begin
            // hi keeps its old value when a period has no falling edge.
            if (w_fall) r_hi <= w_cnt_inc;
            if (w_rise) begin
              r_period <= w_cnt_inc;
              r_high   <= r_hi;
              r_div    <= f_div_count(w_cnt_inc);
              r_valid  <= 1'b1;
              r_locked <= 1'b1;
              r_cnt    <= '0;
            end else if (r_cnt == TO_LAST) begin
              // Partial period is thrown away; re-arm and wait for a fresh edge.
              r_timeout <= 1'b1;
              r_locked  <= 1'b0;
              r_cnt     <= '0;
              r_state   <= S_ARM;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_period    = r_period;
  assign o_high      = r_high;
  assign o_div_count = r_div;
  assign o_valid     = r_valid;
  assign o_locked    = r_locked;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter (SYNC_STAGES=2, TIMEOUT=50).
module tb_clk_period_meter;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_sig;
  logic        i_en;
  logic [31:0] o_period;
  logic [31:0] o_high;
  logic [31:0] o_div_count;
  logic        o_valid;
  logic        o_locked;
  logic        o_timeout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int vcnt     = 0;
  int tocnt    = 0;
  logic [31:0] cap_p = '0;
  logic [31:0] cap_h = '0;
  logic [31:0] cap_d = '0;
  logic        cap_l = 1'b0;
  int          cap_cyc = 0;

  clk_period_meter #(
    .COUNT_WIDTH(32),
    .SYNC_STAGES(2),
    .TIMEOUT(50)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_sig(i_sig),
    .i_en(i_en),
    .o_period(o_period),
    .o_high(o_high),
    .o_div_count(o_div_count),
    .o_valid(o_valid),
    .o_locked(o_locked),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  // edge counter: value n after the n-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // capture every valid pulse and count timeout-high cycles
  always @(negedge clk) begin
    if (o_valid) begin
      vcnt    = vcnt + 1;
      cap_p   = o_period;
      cap_h   = o_high;
      cap_d   = o_div_count;
      cap_l   = o_locked;
      cap_cyc = cyc;
    end
    if (o_timeout) tocnt = tocnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int h, input int l, output int sc);
    sc = cyc;
    i_sig = 1'b1;
    repeat (h) step();
    i_sig = 1'b0;
    repeat (l) step();
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_en = 1'b0; i_sig = 1'b0;
    repeat (3) step();
    i_en = 1'b1; i_sig = 1'b1;
    repeat (4) step();
    i_sig = 1'b0;
    repeat (3) step();
    checks++; if (o_period !== 32'd0) begin failures++; $display("FAIL rst_period got=%0d exp=0", o_period); end
    checks++; if (o_high !== 32'd0) begin failures++; $display("FAIL rst_high got=%0d exp=0", o_high); end
    checks++; if (o_div_count !== 32'd0) begin failures++; $display("FAIL rst_div got=%0d exp=0", o_div_count); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", o_valid); end
    checks++; if (o_locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%b exp=0", o_locked); end
    checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%b exp=0", o_timeout); end
    checks++; if (vcnt !== 0) begin failures++; $display("FAIL rst_novalid got=%0d exp=0", vcnt); end
    i_rst = 1'b0;
  endtask

  task automatic test_divider();
    int sc, v0;
    i_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v0 = vcnt;
      run(5, 5, sc);
      if (k == 0) begin
        checks++; if (vcnt !== v0) begin failures++; $display("FAIL div_first_rise valid_count got=%0d exp=%0d", vcnt, v0); end
      end else begin
        checks++; if (vcnt !== v0 + 1) begin failures++; $display("FAIL div_valid_count got=%0d exp=%0d", vcnt, v0 + 1); end
        checks++; if (cap_p !== 32'd10) begin failures++; $display("FAIL div_period got=%0d exp=10", cap_p); end
        checks++; if (cap_h !== 32'd5) begin failures++; $display("FAIL div_high got=%0d exp=5", cap_h); end
        checks++; if (cap_d !== 32'd4) begin failures++; $display("FAIL div_divcount got=%0d exp=4", cap_d); end
        checks++; if (cap_l !== 1'b1) begin failures++; $display("FAIL div_locked got=%b exp=1", cap_l); end
        checks++; if (cap_cyc !== sc + 3) begin failures++; $display("FAIL div_latency got=%0d exp=%0d", cap_cyc, sc + 3); end
      end
    end
  endtask

  task automatic test_duty();
    int sc, v0;
    v0 = vcnt;
    run(3, 7, sc);
    run(3, 7, sc);
    checks++; if (vcnt !== v0 + 2) begin failures++; $display("FAIL duty_valid_count got=%0d exp=%0d", vcnt, v0 + 2); end
    checks++; if (cap_p !== 32'd10) begin failures++; $display("FAIL duty_period got=%0d exp=10", cap_p); end
    checks++; if (cap_h !== 32'd3) begin failures++; $display("FAIL duty_high got=%0d exp=3", cap_h); end
    checks++; if (cap_d !== 32'd4) begin failures++; $display("FAIL duty_divcount got=%0d exp=4", cap_d); end
    for (int k = 0; k < 4; k++) run(1, 1, sc);
    repeat (4) step();
    checks++; if (vcnt !== v0 + 6) begin failures++; $display("FAIL minper_valid_count got=%0d exp=%0d", vcnt, v0 + 6); end
    checks++; if (cap_p !== 32'd2) begin failures++; $display("FAIL minper_period got=%0d exp=2", cap_p); end
    checks++; if (cap_h !== 32'd1) begin failures++; $display("FAIL minper_high got=%0d exp=1", cap_h); end
    checks++; if (cap_d !== 32'd0) begin failures++; $display("FAIL minper_divcount got=%0d exp=0", cap_d); end
    checks++; if (o_locked !== 1'b1) begin failures++; $display("FAIL minper_locked got=%b exp=1", o_locked); end
  endtask

  task automatic test_timeout();
    int sc, v0, vc, tcyc;
    bit found;
    v0 = vcnt;
    run(5, 5, sc);
    run(5, 5, sc);
    checks++; if (vcnt !== v0 + 2) begin failures++; $display("FAIL to_lock_valid_count got=%0d exp=%0d", vcnt, v0 + 2); end
    vc = cap_cyc;
    found = 1'b0;
    tcyc = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      step();
      if (o_timeout === 1'b1) begin
        found = 1'b1;
        tcyc = cyc;
      end
    end
    checks++; if (!found) begin failures++; $display("FAIL to_seen got=0 exp=1"); end
    checks++; if (tcyc !== vc + 50) begin failures++; $display("FAIL to_cycle got=%0d exp=%0d", tcyc, vc + 50); end
    checks++; if (o_locked !== 1'b0) begin failures++; $display("FAIL to_locked got=%b exp=0", o_locked); end
    checks++; if (o_period !== 32'd10) begin failures++; $display("FAIL to_period_hold got=%0d exp=10", o_period); end
    v0 = vcnt;
    run(5, 5, sc);
    checks++; if (vcnt !== v0) begin failures++; $display("FAIL to_rearm_novalid got=%0d exp=%0d", vcnt, v0); end
    checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", o_timeout); end
    checks++; if (o_locked !== 1'b0) begin failures++; $display("FAIL to_rearm_locked got=%b exp=0", o_locked); end
    run(5, 5, sc);
    checks++; if (vcnt !== v0 + 1) begin failures++; $display("FAIL to_relock_valid_count got=%0d exp=%0d", vcnt, v0 + 1); end
    checks++; if (cap_p !== 32'd10) begin failures++; $display("FAIL to_relock_period got=%0d exp=10", cap_p); end
    checks++; if (o_locked !== 1'b1) begin failures++; $display("FAIL to_relock_locked got=%b exp=1", o_locked); end
  endtask

  task automatic test_boundary();
    int sc, v0, t0;
    v0 = vcnt;
    t0 = tocnt;
    run(25, 25, sc);
    run(25, 25, sc);
    checks++; if (vcnt !== v0 + 2) begin failures++; $display("FAIL bnd_valid_count got=%0d exp=%0d", vcnt, v0 + 2); end
    checks++; if (cap_p !== 32'd50) begin failures++; $display("FAIL bnd_period got=%0d exp=50", cap_p); end
    checks++; if (cap_h !== 32'd25) begin failures++; $display("FAIL bnd_high got=%0d exp=25", cap_h); end
    checks++; if (cap_d !== 32'd24) begin failures++; $display("FAIL bnd_divcount got=%0d exp=24", cap_d); end
    checks++; if (tocnt !== t0) begin failures++; $display("FAIL bnd_timeout_cycles got=%0d exp=%0d", tocnt, t0); end
    checks++; if (o_locked !== 1'b1) begin failures++; $display("FAIL bnd_locked got=%b exp=1", o_locked); end
  endtask

  task automatic test_enable_reset();
    int sc, v0, v1, v2;
    v0 = vcnt;
    run(5, 5, sc);
    run(5, 5, sc);
    checks++; if (cap_p !== 32'd10 || cap_h !== 32'd5) begin failures++; $display("FAIL en_pre_result got=%0d/%0d exp=10/5", cap_p, cap_h); end
    i_sig = 1'b1; repeat (6) step();
    i_sig = 1'b0; repeat (2) step();
    checks++; if (vcnt !== v0 + 3) begin failures++; $display("FAIL en_pre_valid_count got=%0d exp=%0d", vcnt, v0 + 3); end
    i_en = 1'b0;
    step();
    checks++; if (o_locked !== 1'b0) begin failures++; $display("FAIL en_off_locked got=%b exp=0", o_locked); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL en_off_valid got=%b exp=0", o_valid); end
    checks++; if (o_period !== 32'd10) begin failures++; $display("FAIL en_off_period got=%0d exp=10", o_period); end
    checks++; if (o_high !== 32'd5) begin failures++; $display("FAIL en_off_high got=%0d exp=5", o_high); end
    checks++; if (o_div_count !== 32'd4) begin failures++; $display("FAIL en_off_div got=%0d exp=4", o_div_count); end
    v1 = vcnt;
    run(5, 5, sc);
    run(5, 5, sc);
    checks++; if (vcnt !== v1) begin failures++; $display("FAIL en_off_novalid got=%0d exp=%0d", vcnt, v1); end
    checks++; if (o_period !== 32'd10) begin failures++; $display("FAIL en_off_hold got=%0d exp=10", o_period); end
    i_en = 1'b1;
    run(5, 5, sc);
    checks++; if (vcnt !== v1) begin failures++; $display("FAIL en_first_rise got=%0d exp=%0d", vcnt, v1); end
    run(4, 6, sc);
    checks++; if (vcnt !== v1 + 1) begin failures++; $display("FAIL en_second_rise got=%0d exp=%0d", vcnt, v1 + 1); end
    checks++; if (cap_p !== 32'd10 || cap_h !== 32'd5) begin failures++; $display("FAIL en_result got=%0d/%0d exp=10/5", cap_p, cap_h); end
    i_sig = 1'b1; repeat (5) step();
    i_sig = 1'b0; repeat (2) step();
    checks++; if (cap_h !== 32'd4 || cap_d !== 32'd4) begin failures++; $display("FAIL en_high4 got=%0d/%0d exp=4/4", cap_h, cap_d); end
    v2 = vcnt;
    i_rst = 1'b1;
    step();
    checks++; if (o_period !== 32'd0) begin failures++; $display("FAIL mrst_period got=%0d exp=0", o_period); end
    checks++; if (o_high !== 32'd0) begin failures++; $display("FAIL mrst_high got=%0d exp=0", o_high); end
    checks++; if (o_div_count !== 32'd0) begin failures++; $display("FAIL mrst_div got=%0d exp=0", o_div_count); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL mrst_valid got=%b exp=0", o_valid); end
    checks++; if (o_locked !== 1'b0) begin failures++; $display("FAIL mrst_locked got=%b exp=0", o_locked); end
    checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL mrst_timeout got=%b exp=0", o_timeout); end
    i_rst = 1'b0;
    step();
    checks++; if (vcnt !== v2) begin failures++; $display("FAIL mrst_novalid got=%0d exp=%0d", vcnt, v2); end
    run(5, 5, sc);
    checks++; if (vcnt !== v2) begin failures++; $display("FAIL mrst_first_rise got=%0d exp=%0d", vcnt, v2); end
    run(5, 5, sc);
    checks++; if (vcnt !== v2 + 1) begin failures++; $display("FAIL mrst_second_rise got=%0d exp=%0d", vcnt, v2 + 1); end
    checks++; if (cap_p !== 32'd10 || cap_h !== 32'd5 || cap_d !== 32'd4) begin failures++; $display("FAIL mrst_result got=%0d/%0d/%0d exp=10/5/4", cap_p, cap_h, cap_d); end
  endtask

  initial begin
    i_rst = 1'b1;
    i_en  = 1'b0;
    i_sig = 1'b0;
    test_reset();
    test_divider();
    test_duty();
    test_timeout();
    test_boundary();
    test_enable_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
